// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM encoding, bus widths
// and the round-robin pick used whenever the arbiter (re)arbitrates.
package wb_arb_pkg;

    localparam int WB_DAT_W  = 32;
    localparam int WB_SEL_W  = 4;
    localparam int TMO_CNT_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GNT0  = 2'b01,
        ARB_GNT1  = 2'b10,
        ARB_ABORT = 2'b11
    } arb_state_e;

    // On a tie the master that did not win last time gets the bus.
    function automatic arb_state_e arb_pick(input logic cyc0, input logic cyc1, input logic last);
        arb_state_e pick;
        pick = ARB_IDLE;
        if (cyc0 && cyc1) begin
            pick = last ? ARB_GNT0 : ARB_GNT1;
        end else if (cyc0) begin
            pick = ARB_GNT0;
        end else if (cyc1) begin
            pick = ARB_GNT1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Stalled-strobe watchdog: counts strobe cycles without ack and flags when the
// count reaches timeout_cycles. Only instantiated when WB_ARB2_TIMEOUT_EN is defined.
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int timeout_cycles = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    localparam logic [TMO_CNT_W-1:0] LIMIT = TMO_CNT_W'(timeout_cycles);

    logic [TMO_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && !expired) begin
            cnt <= cnt + TMO_CNT_W'(1);
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/wb_arb2.sv
// Two-master to one-slave Wishbone arbiter, round-robin, whole-cycle grants.
// Optional stalled-strobe timeout with bus error: define WB_ARB2_TIMEOUT_EN.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ARB_IDLE  | no grant, slave outputs parked at 0
//   ARB_GNT0  | master 0 owns the slave until it drops cyc
//   ARB_GNT1  | master 1 owns the slave until it drops cyc
//   ARB_ABORT | timed-out cycle: slave idle until the owner drops cyc
module wb_arb2
    import wb_arb_pkg::*;
#(
    parameter int adr_width      = 32,
    parameter int timeout_cycles = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic [adr_width-1:0] m0_adr_i,
    input  logic [WB_DAT_W-1:0]  m0_dat_i,
    input  logic [WB_SEL_W-1:0]  m0_sel_i,
    input  logic                 m0_we_i,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    output logic [WB_DAT_W-1:0]  m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,

    input  logic [adr_width-1:0] m1_adr_i,
    input  logic [WB_DAT_W-1:0]  m1_dat_i,
    input  logic [WB_SEL_W-1:0]  m1_sel_i,
    input  logic                 m1_we_i,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    output logic [WB_DAT_W-1:0]  m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,

    output logic [adr_width-1:0] s_adr_o,
    output logic [WB_DAT_W-1:0]  s_dat_o,
    output logic [WB_SEL_W-1:0]  s_sel_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    input  logic [WB_DAT_W-1:0]  s_dat_i,
    input  logic                 s_ack_i
);

    arb_state_e state, state_next;
    logic       last;
    logic       gnt0, gnt1;
    logic       tmo_hit;

    assign gnt0 = (state == ARB_GNT0);
    assign gnt1 = (state == ARB_GNT1);

`ifdef WB_ARB2_TIMEOUT_EN
    logic tmo_expired;
    logic tmo_count;
    logic tmo_clear;

    assign tmo_count = (gnt0 || gnt1) && s_stb_o && !s_ack_i;
    assign tmo_clear = s_ack_i || (state_next != state);

    wb_arb_timeout #(
        .timeout_cycles(timeout_cycles)
    ) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .count_en (tmo_count),
        .clear    (tmo_clear),
        .expired  (tmo_expired)
    );

    // A late ack or a release in the same cycle wins over the timeout.
    assign tmo_hit = tmo_expired && !s_ack_i &&
                     ((gnt0 && m0_cyc_i) || (gnt1 && m1_cyc_i));
`else
    logic unused_cfg;
    assign unused_cfg = (timeout_cycles != 0);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            if (state_next == ARB_GNT0) begin
                last <= 1'b0;
            end else if (state_next == ARB_GNT1) begin
                last <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: state_next = arb_pick(m0_cyc_i, m1_cyc_i, last);
            ARB_GNT0: begin
                if (!m0_cyc_i) begin
                    state_next = arb_pick(1'b0, m1_cyc_i, last);
                end else if (tmo_hit) begin
                    state_next = ARB_ABORT;
                end
            end
            ARB_GNT1: begin
                if (!m1_cyc_i) begin
                    state_next = arb_pick(m0_cyc_i, 1'b0, last);
                end else if (tmo_hit) begin
                    state_next = ARB_ABORT;
                end
            end
`ifdef WB_ARB2_TIMEOUT_EN
            // last still names the aborted master, so its cyc gates the exit.
            ARB_ABORT: begin
                if (!(last ? m1_cyc_i : m0_cyc_i)) begin
                    state_next = arb_pick(m0_cyc_i, m1_cyc_i, last);
                end
            end
`endif
            default: state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        if (gnt0 && !tmo_hit) begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            m0_ack_o = s_ack_i && m0_stb_i && m0_cyc_i;
        end else if (gnt1 && !tmo_hit) begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            m1_ack_o = s_ack_i && m1_stb_i && m1_cyc_i;
        end
    end

    assign m0_err_o = gnt0 && tmo_hit;
    assign m1_err_o = gnt1 && tmo_hit;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arb2.sv
// Self-checking bench for wb_arb2: master BFMs, a latency-programmable slave and a
// scoreboard of expected grant order / transfer contents.
`timescale 1ns/1ps
module tb_wb_arb2;

    typedef struct {
        int          id;
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic        m_we  [2];
    logic        m_cyc [2];
    logic        m_stb [2];
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [31:0] slv_rdata;
    logic        s_ack_i;

    int   slv_lat;
    bit   slv_en;
    bit   slv_force;
    int   slv_wait = 0;
    int   checks = 0;
    int   errors = 0;
    int   dual_ack = 0;
    txn_t exp_q[$];

    always #5 clk = ~clk;

    wb_arb2 #(.adr_width(32), .timeout_cycles(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(slv_rdata), .s_ack_i(s_ack_i)
    );

    // Slave model: acks once the strobe has been stalled slv_lat cycles.
    always @(negedge clk) begin
        if (s_cyc_o && s_stb_o && !s_ack_i) slv_wait = slv_wait + 1;
        else slv_wait = 0;
        if (m0_ack_o && m1_ack_o) dual_ack = dual_ack + 1;
    end

    always @(posedge clk) begin
        #2;
        s_ack_i = slv_force || (slv_en && s_cyc_o && s_stb_o && (slv_wait >= slv_lat));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input int id, input logic [31:0] adr, input logic we,
                            input logic [3:0] sel, input logic [31:0] dat);
        txn_t t;
        t.id = id; t.adr = adr; t.we = we; t.sel = sel; t.dat = dat;
        exp_q.push_back(t);
    endtask

    // Master BFM: single-beat cycle; pops the scoreboard when its ack arrives.
    task automatic master_txn(input int id, input logic [31:0] adr, input logic we,
                              input logic [3:0] sel, input logic [31:0] wdat);
        txn_t        e;
        bit          got;
        logic        ack;
        logic [31:0] dat;
        m_adr[id] = adr; m_we[id] = we; m_sel[id] = sel; m_dat[id] = wdat;
        m_cyc[id] = 1'b1; m_stb[id] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            ack = (id == 0) ? m0_ack_o : m1_ack_o;
            if (ack) begin
                got = 1'b1;
                dat = we ? s_dat_o : ((id == 0) ? m0_dat_o : m1_dat_o);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: m%0d acked adr=%h, required no further transfer", id, s_adr_o);
                end else begin
                    e = exp_q.pop_front();
                    if (id !== e.id || s_adr_o !== e.adr || s_we_o !== e.we || s_sel_o !== e.sel || dat !== e.dat) begin
                        errors++;
                        $display("FAIL sb_txn: got m%0d adr=%h we=%b sel=%h dat=%h, required m%0d adr=%h we=%b sel=%h dat=%h",
                                 id, s_adr_o, s_we_o, s_sel_o, dat, e.id, e.adr, e.we, e.sel, e.dat);
                    end
                end
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL txn_ack_timeout: m%0d got no ack, required ack within 60 cycles", id);
        end
        tick();
        m_cyc[id] = 1'b0; m_stb[id] = 1'b0; m_we[id] = 1'b0;
        m_sel[id] = '0; m_adr[id] = '0; m_dat[id] = '0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        s_ack_i = 1'b0; slv_force = 1'b0; slv_en = 1'b1; slv_lat = 2; slv_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0;
            m_we[i] = 1'b0; m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: cyc/stb/we=%b, required 000", {s_cyc_o, s_stb_o, s_we_o});
        end
        checks++;
        if (s_adr_o !== 32'h0 || s_dat_o !== 32'h0 || s_sel_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_bus: adr=%h dat=%h sel=%h, required all 0", s_adr_o, s_dat_o, s_sel_o);
        end
        checks++;
        if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_master: ack0 ack1 err0 err1=%b, required 0000",
                     {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int n0, n1;
        n0 = 0; n1 = 0;
        slv_rdata = 32'hDEADBEEF; slv_lat = 2;
        exp_push(0, 32'h40000010, 1'b0, 4'hF, 32'hDEADBEEF);
        fork
            master_txn(0, 32'h40000010, 1'b0, 4'hF, 32'h0);
            begin
                @(negedge clk);
                checks++;
                if (s_cyc_o !== 1'b0) begin
                    errors++;
                    $display("FAIL read_latency_early: s_cyc_o=%b in request cycle, required 0", s_cyc_o);
                end
                @(negedge clk);
                checks++;
                if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_adr_o !== 32'h40000010) begin
                    errors++;
                    $display("FAIL read_latency: cyc=%b stb=%b adr=%h one clk after request, required 1 1 40000010",
                             s_cyc_o, s_stb_o, s_adr_o);
                end
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    if (m0_ack_o) n0++;
                    if (m1_ack_o) n1++;
                end
            end
        join
        checks++;
        if (n0 !== 1 || n1 !== 0) begin
            errors++;
            $display("FAIL read_ack_count: m0 acks=%0d m1 acks=%0d, required 1 and 0", n0, n1);
        end
    endtask

    task automatic test_round_robin();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        slv_rdata = 32'hA5A50F0F; slv_lat = 1;
        for (int k = 0; k < 3; k++) begin
            exp_push(0, 32'h00001000 + 32'(k * 4), 1'b0, 4'hF, 32'hA5A50F0F);
            exp_push(1, 32'h00002000 + 32'(k * 4), 1'b0, 4'hF, 32'hA5A50F0F);
        end
        fork
            for (int k = 0; k < 3; k++) master_txn(0, 32'h00001000 + 32'(k * 4), 1'b0, 4'hF, 32'h0);
            for (int k = 0; k < 3; k++) master_txn(1, 32'h00002000 + 32'(k * 4), 1'b0, 4'hF, 32'h0);
        join
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL rr_leftover: %0d transfers never completed, required 0", exp_q.size());
        end
    endtask

    task automatic test_write_contention();
        int early;
        early = 0;
        slv_rdata = 32'hCAFEF00D; slv_lat = 3;
        exp_push(1, 32'h30000020, 1'b1, 4'b0011, 32'h12345678);
        exp_push(0, 32'h30000040, 1'b0, 4'hF, 32'hCAFEF00D);
        fork
            master_txn(1, 32'h30000020, 1'b1, 4'b0011, 32'h12345678);
            begin
                tick();
                master_txn(0, 32'h30000040, 1'b0, 4'hF, 32'h0);
            end
            for (int i = 0; i < 14; i++) begin
                @(negedge clk);
                if (m0_ack_o && m_cyc[1]) early++;
            end
        join
        checks++;
        if (early !== 0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL write_stall: m0 acks while m1 held cyc=%0d leftover=%0d, required 0 and 0",
                     early, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        slv_en = 1'b0;
        m_adr[1] = 32'h50000000; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick();
        slv_force = 1'b1;
        @(negedge clk);
        checks++;
        if (s_cyc_o !== 1'b1 || m1_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: cyc=%b m1_ack=%b while granted, required 1 1", s_cyc_o, m1_ack_o);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid: cyc stb ack0 ack1=%b right after reset, required 0000",
                     {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o});
        end
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_adr[1] = '0;
        slv_force = 1'b0; slv_en = 1'b1; slv_lat = 1;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        slv_rdata = 32'h0BADF00D;
        exp_push(0, 32'h60000000, 1'b0, 4'hF, 32'h0BADF00D);
        exp_push(1, 32'h60000100, 1'b0, 4'hF, 32'h0BADF00D);
        fork
            master_txn(0, 32'h60000000, 1'b0, 4'hF, 32'h0);
            master_txn(1, 32'h60000100, 1'b0, 4'hF, 32'h0);
        join
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL rst_tie_leftover: %0d transfers never completed, required 0", exp_q.size());
        end
    endtask

    task automatic test_spurious_ack();
        slv_force = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({m0_ack_o, m1_ack_o, s_cyc_o} !== 3'b000) begin
                errors++;
                $display("FAIL idle_ack: ack0 ack1 cyc=%b with spurious s_ack_i, required 000",
                         {m0_ack_o, m1_ack_o, s_cyc_o});
            end
        end
        tick();
        m_adr[0] = 32'h70000000; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (m0_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_req: m0_ack_o=%b before grant, required 0", m0_ack_o);
        end
        @(negedge clk);
        checks++;
        if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL gnt_ack: m0_ack=%b m1_ack=%b once granted, required 1 0", m0_ack_o, m1_ack_o);
        end
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_adr[0] = '0;
        slv_force = 1'b0;
        tick();
        tick();
    endtask

`ifdef WB_ARB2_TIMEOUT_EN
    task automatic test_timeout();
        logic exp_err, exp_cyc;
        slv_en = 1'b0;
        m_adr[0] = 32'h40000080; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_err = (k == 9);
            exp_cyc = (k >= 1 && k <= 8);
            checks++;
            if (m0_err_o !== exp_err || s_cyc_o !== exp_cyc || m1_err_o !== 1'b0) begin
                errors++;
                $display("FAIL tmo_cycle%0d: err0=%b err1=%b cyc=%b, required %b 0 %b",
                         k, m0_err_o, m1_err_o, s_cyc_o, exp_err, exp_cyc);
            end
        end
        tick();
        m_adr[1] = 32'h40000200; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({m0_err_o, s_cyc_o, s_stb_o} !== 3'b000) begin
                errors++;
                $display("FAIL tmo_abort%0d: err0 cyc stb=%b while aborted, required 000",
                         k, {m0_err_o, s_cyc_o, s_stb_o});
            end
        end
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_adr[0] = '0;
        @(negedge clk);
        checks++;
        if (s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_release: s_cyc_o=%b in release cycle, required 0", s_cyc_o);
        end
        @(negedge clk);
        checks++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h40000200) begin
            errors++;
            $display("FAIL tmo_handover: cyc=%b adr=%h, required 1 40000200", s_cyc_o, s_adr_o);
        end
        tick();
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_adr[1] = '0;
        slv_en = 1'b1;
        tick();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_contention();
        test_reset_mid();
        test_spurious_ack();
`ifdef WB_ARB2_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (dual_ack !== 0) begin
            errors++;
            $display("FAIL dual_ack: both acks high in %0d cycles, required 0", dual_ack);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
